// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: control and hazard unit for the 5-stage MIPS-subset pipeline.
//
// Decodes Opcode/Funct in D and carries the control bits through the E, M and
// W stage registers in step with the datapath. Stalls F/D on RAW hazards
// (there is no forwarding), squashes younger instructions when a branch
// resolves taken in M, and keeps retired/stall counters for bring-up.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   Opcode, Funct         InstrD[31:26], InstrD[5:0]
//   RsD, RtD              source register specifiers of the D instruction
//   ZeroM                 registered ALU zero of the instruction in M
//   WriteRegE/M/W         destination register of the E/M/W instruction
//   RegDstE, ALUSrcBE,
//   ALUControlE           E-stage datapath controls
//   MemWriteM, PCSrcM     M-stage datapath controls
//   MemToRegW, RegWriteW  W-stage datapath controls
//   StallF, StallD        hold PC and D-stage registers
//   FlushD                clear InstrD to nop
//   illegal_op            one-cycle pulse after an unknown opcode/funct leaves D
//   retired               instructions that completed W with their valid bit
//   stall_cycles          cycles with StallD asserted
module pipeline_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              ZeroM,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    output logic              RegDstE,
    output logic              ALUSrcBE,
    output logic [2:0]        ALUControlE,
    output logic              MemWriteM,
    output logic              PCSrcM,
    output logic              MemToRegW,
    output logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // ---- D stage (p0): combinational decode ----
    logic       reg_write_p0, mem_to_reg_p0, mem_write_p0, branch_p0;
    logic       reg_dst_p0, alu_src_p0, illegal_p0;
    logic [2:0] alu_ctrl_p0;

    always_comb begin
        reg_write_p0  = 1'b0;
        mem_to_reg_p0 = 1'b0;
        mem_write_p0  = 1'b0;
        branch_p0     = 1'b0;
        reg_dst_p0    = 1'b0;
        alu_src_p0    = 1'b0;
        alu_ctrl_p0   = ALU_AND;
        illegal_p0    = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                reg_write_p0 = 1'b1;
                reg_dst_p0   = 1'b1;
                case (Funct)
                    // sll only appears as the all-zero nop; it writes $0,
                    // so any ALU op is harmless and add is used.
                    FN_SLL, FN_ADD: alu_ctrl_p0 = ALU_ADD;
                    FN_SUB:         alu_ctrl_p0 = ALU_SUB;
                    FN_AND:         alu_ctrl_p0 = ALU_AND;
                    FN_OR:          alu_ctrl_p0 = ALU_OR;
                    FN_SLT:         alu_ctrl_p0 = ALU_SLT;
                    default: begin
                        reg_write_p0 = 1'b0;
                        reg_dst_p0   = 1'b0;
                        illegal_p0   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                reg_write_p0  = 1'b1;
                mem_to_reg_p0 = 1'b1;
                alu_src_p0    = 1'b1;
                alu_ctrl_p0   = ALU_ADD;
            end
            OP_SW: begin
                mem_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                alu_ctrl_p0  = ALU_ADD;
            end
            OP_BEQ: begin
                branch_p0   = 1'b1;
                alu_ctrl_p0 = ALU_SUB;
            end
            OP_ADDI: begin
                reg_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                alu_ctrl_p0  = ALU_ADD;
            end
            default: illegal_p0 = 1'b1;
        endcase
    end

    // Stage registers: p1 = E, p2 = M, p3 = W.
    logic       vld_p1, reg_write_p1, mem_to_reg_p1, mem_write_p1, branch_p1;
    logic       reg_dst_p1, alu_src_p1;
    logic [2:0] alu_ctrl_p1;
    logic       vld_p2, reg_write_p2, mem_to_reg_p2, mem_write_p2, branch_p2;
    logic       vld_p3, reg_write_p3, mem_to_reg_p3;
    // Set for the cycle after a taken branch: InstrD then holds the nop that
    // FlushD wrote over the wrong-path fetch, which is a bubble rather than
    // a real instruction and must neither retire nor raise illegal_op.
    logic       flushed_p0;
    logic       illegal_q;
    logic [CNT_W-1:0] retired_q, stall_q;

    // Without forwarding, a source must wait until its producer has left W;
    // the W match is needed because the register file does not bypass.
    logic hit_e, hit_m, hit_w, hazard, pc_src, stall, kill_d;

    assign hit_e  = reg_write_p1 && (WriteRegE != '0) && (WriteRegE == RsD || WriteRegE == RtD);
    assign hit_m  = reg_write_p2 && (WriteRegM != '0) && (WriteRegM == RsD || WriteRegM == RtD);
    assign hit_w  = reg_write_p3 && (WriteRegW != '0) && (WriteRegW == RsD || WriteRegW == RtD);
    assign hazard = hit_e | hit_m | hit_w;
    assign pc_src = branch_p2 & ZeroM;
    // The flush squashes the stalled instruction anyway, so it wins.
    assign stall  = hazard & ~pc_src;
    assign kill_d = pc_src | stall | flushed_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_write_p1  <= 1'b0;
            branch_p1     <= 1'b0;
            reg_dst_p1    <= 1'b0;
            alu_src_p1    <= 1'b0;
            alu_ctrl_p1   <= 3'b000;
            vld_p2        <= 1'b0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            mem_write_p2  <= 1'b0;
            branch_p2     <= 1'b0;
            vld_p3        <= 1'b0;
            reg_write_p3  <= 1'b0;
            mem_to_reg_p3 <= 1'b0;
            flushed_p0    <= 1'b0;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
            stall_q       <= '0;
        end else begin
            // ---- D -> E: bubble when stalled, squashed or a flushed slot ----
            vld_p1        <= ~kill_d;
            reg_write_p1  <= reg_write_p0  & ~kill_d;
            mem_to_reg_p1 <= mem_to_reg_p0 & ~kill_d;
            mem_write_p1  <= mem_write_p0  & ~kill_d;
            branch_p1     <= branch_p0     & ~kill_d;
            reg_dst_p1    <= reg_dst_p0    & ~kill_d;
            alu_src_p1    <= alu_src_p0    & ~kill_d;
            alu_ctrl_p1   <= kill_d ? 3'b000 : alu_ctrl_p0;
            // ---- E -> M: bubble when a taken branch squashes E ----
            vld_p2        <= vld_p1        & ~pc_src;
            reg_write_p2  <= reg_write_p1  & ~pc_src;
            mem_to_reg_p2 <= mem_to_reg_p1 & ~pc_src;
            mem_write_p2  <= mem_write_p1  & ~pc_src;
            branch_p2     <= branch_p1     & ~pc_src;
            // ---- M -> W: always advances, including the branch itself ----
            vld_p3        <= vld_p2;
            reg_write_p3  <= reg_write_p2;
            mem_to_reg_p3 <= mem_to_reg_p2;
            flushed_p0    <= pc_src;
            illegal_q     <= illegal_p0 & ~kill_d;
            retired_q     <= retired_q + CNT_W'(vld_p3);
            stall_q       <= stall_q + CNT_W'(stall);
        end
    end

    assign RegDstE      = reg_dst_p1;
    assign ALUSrcBE     = alu_src_p1;
    assign ALUControlE  = alu_ctrl_p1;
    assign MemWriteM    = mem_write_p2;
    assign PCSrcM       = pc_src;
    assign MemToRegW    = mem_to_reg_p3;
    assign RegWriteW    = reg_write_p3;
    assign StallF       = stall;
    assign StallD       = stall;
    assign FlushD       = pc_src;
    assign illegal_op   = illegal_q;
    assign retired      = retired_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        Opcode, Funct;
    logic [REG_AW-1:0] RsD, RtD, WriteRegE, WriteRegM, WriteRegW;
    logic              ZeroM;
    logic              RegDstE, ALUSrcBE, MemWriteM, PCSrcM, MemToRegW, RegWriteW;
    logic              StallF, StallD, FlushD, illegal_op;
    logic [2:0]        ALUControlE;
    logic [CNT_W-1:0]  retired, stall_cycles;

    pipeline_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .RsD(RsD), .RtD(RtD),
        .ZeroM(ZeroM), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegDstE(RegDstE), .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE),
        .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .MemToRegW(MemToRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .illegal_op(illegal_op),
        .retired(retired), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // An instruction as it moves down the pipe; v=0 is a bubble.
    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } instr_t;

    typedef struct packed {
        logic       known;
        logic       rw;
        logic       m2r;
        logic       mw;
        logic       br;
        logic       rd;
        logic       asrc;
        logic [2:0] alu;
    } ctl_t;

    // Reference pipeline: instruction records per stage.
    instr_t s_e, s_m, s_w, cur_d;
    logic   d_fl, m_ill;
    logic [CNT_W-1:0] m_ret, m_stall;
    ctl_t   ce, cm, cw;
    logic   x_haz, x_pcsrc, x_stall;
    logic   zero_drv;
    instr_t prog[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
        instr_t i;
        i.v = 1'b1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.dst = dst;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    endfunction

    // Instruction-set table: what each instruction asks of the datapath.
    function automatic ctl_t ref_ctl(input instr_t i);
        ctl_t c;
        c = '0;
        if (!i.v) return c;
        case (i.op)
            6'b000000: begin
                c.known = 1'b1; c.rw = 1'b1; c.rd = 1'b1;
                case (i.fn)
                    6'b000000, 6'b100000: c.alu = 3'b010;
                    6'b100010:            c.alu = 3'b110;
                    6'b100100:            c.alu = 3'b000;
                    6'b100101:            c.alu = 3'b001;
                    6'b101010:            c.alu = 3'b111;
                    default:              c = '0;
                endcase
            end
            6'b100011: begin c.known = 1'b1; c.rw = 1'b1; c.m2r = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            6'b101011: begin c.known = 1'b1; c.mw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            6'b000100: begin c.known = 1'b1; c.br = 1'b1; c.alu = 3'b110; end
            6'b001000: begin c.known = 1'b1; c.rw = 1'b1; c.asrc = 1'b1; c.alu = 3'b010; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic writes(input instr_t s, input logic [4:0] r);
        ctl_t c;
        c = ref_ctl(s);
        return c.rw && (s.dst != 5'd0) && (s.dst == r);
    endfunction

    function automatic instr_t rand_instr();
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        int k = $urandom_range(0, 9);
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        case (k)
            0, 1:    return mk(6'd0, fns[$urandom_range(0, 4)], rs, rt, rd);
            2:       return mk(6'd0, 6'($urandom), rs, rt, rd);
            3, 4:    return mk(6'b100011, 6'($urandom), rs, rt, rt);
            5:       return mk(6'b101011, 6'($urandom), rs, rt, rd);
            6:       return mk(6'b000100, 6'($urandom), rs, rt, rd);
            7, 8:    return mk(6'b001000, 6'($urandom), rs, rt, rt);
            default: return mk(6'($urandom), 6'($urandom), rs, rt, rd);
        endcase
    endfunction

    task automatic model_reset();
        s_e = '0; s_m = '0; s_w = '0; cur_d = nop();
        d_fl = 1'b0; m_ill = 1'b0; m_ret = '0; m_stall = '0;
    endtask

    // Present the D instruction and the datapath's view of E/M/W, then work
    // out what the pipeline must show this cycle.
    task automatic drive_eval();
        Opcode    = cur_d.op;
        Funct     = cur_d.fn;
        RsD       = cur_d.rs;
        RtD       = cur_d.rt;
        WriteRegE = s_e.v ? s_e.dst : 5'($urandom);
        WriteRegM = s_m.v ? s_m.dst : 5'($urandom);
        WriteRegW = s_w.v ? s_w.dst : 5'($urandom);
        ZeroM     = zero_drv;
        #1;
        ce = ref_ctl(s_e);
        cm = ref_ctl(s_m);
        cw = ref_ctl(s_w);
        x_haz = writes(s_e, cur_d.rs) || writes(s_e, cur_d.rt) ||
                writes(s_m, cur_d.rs) || writes(s_m, cur_d.rt) ||
                writes(s_w, cur_d.rs) || writes(s_w, cur_d.rt);
        x_pcsrc = cm.br && zero_drv;
        x_stall = x_haz && !x_pcsrc;
    endtask

    // Move every instruction one stage on, as the clock edge will.
    task automatic advance();
        ctl_t cd;
        if (!reset) begin
            model_reset();
        end else begin
            cd      = ref_ctl(cur_d);
            m_ret   = m_ret + CNT_W'(s_w.v);
            m_stall = m_stall + CNT_W'(x_stall);
            m_ill   = cur_d.v && !cd.known && !x_pcsrc && !x_stall && !d_fl;
            s_w     = s_m;
            s_m     = x_pcsrc ? instr_t'('0) : s_e;
            s_e     = (x_pcsrc || x_stall || d_fl) ? instr_t'('0) : cur_d;
            if (x_pcsrc)
                cur_d = nop();
            else if (!x_stall)
                cur_d = (prog.size() > 0) ? prog.pop_front() : nop();
            d_fl = x_pcsrc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        prog.delete();
        cur_d = nop();
        repeat (n) begin
            drive_eval();
            advance();
        end
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int c = 0; c < 6; c++) begin
            drive_eval();
            if (c == 0) begin
                n_checks++;
                if ({RegDstE, ALUSrcBE, ALUControlE, MemWriteM, PCSrcM, MemToRegW, RegWriteW,
                     StallF, StallD, FlushD, illegal_op, retired, stall_cycles} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs got ret=%0d stall=%0d rw=%b want all zero",
                             retired, stall_cycles, RegWriteW);
                end
            end
            n_checks++;
            if (retired !== CNT_W'((c >= 4) ? c - 3 : 0)) begin
                n_fail++;
                $display("FAIL reset_retired c=%0d got %0d want %0d", c, retired, (c >= 4) ? c - 3 : 0);
            end
            n_checks++;
            if (RegWriteW !== (c >= 3)) begin
                n_fail++;
                $display("FAIL reset_regwritew c=%0d got %b want %b", c, RegWriteW, c >= 3);
            end
            advance();
        end
    endtask

    task automatic test_independent();
        do_reset(1);
        prog.push_back(mk(6'd0, 6'b100000, 5'd1, 5'd2, 5'd3));
        prog.push_back(mk(6'b001000, 6'd7, 5'd4, 5'd5, 5'd5));
        cur_d = prog.pop_front();
        for (int c = 0; c < 7; c++) begin
            drive_eval();
            n_checks++;
            if (StallD !== 1'b0) begin
                n_fail++;
                $display("FAIL indep_stall c=%0d got %b want 0", c, StallD);
            end
            if (c == 1) begin
                n_checks++;
                if ({RegDstE, ALUControlE} !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL indep_add_e got %b want 1010", {RegDstE, ALUControlE});
                end
            end
            if (c == 2) begin
                n_checks++;
                if (ALUSrcBE !== 1'b1) begin
                    n_fail++;
                    $display("FAIL indep_addi_e got %b want 1", ALUSrcBE);
                end
            end
            if (c <= 4) begin
                n_checks++;
                if (RegWriteW !== (c >= 3)) begin
                    n_fail++;
                    $display("FAIL indep_regwritew c=%0d got %b want %b", c, RegWriteW, c >= 3);
                end
            end
            n_checks++;
            if ({RegDstE, ALUSrcBE, ALUControlE} !== {ce.rd, ce.asrc, ce.alu}) begin
                n_fail++;
                $display("FAIL indep_ctl_e c=%0d got %b want %b", c,
                         {RegDstE, ALUSrcBE, ALUControlE}, {ce.rd, ce.asrc, ce.alu});
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        do_reset(1);
        prog.push_back(mk(6'b100011, 6'd0, 5'd0, 5'd2, 5'd2));
        prog.push_back(mk(6'd0, 6'b100000, 5'd2, 5'd2, 5'd4));
        cur_d = prog.pop_front();
        for (int c = 0; c < 9; c++) begin
            drive_eval();
            n_checks++;
            if ({StallF, StallD} !== {2{c >= 1 && c <= 3}}) begin
                n_fail++;
                $display("FAIL loaduse_stall c=%0d got %b want %b", c, {StallF, StallD}, {2{c >= 1 && c <= 3}});
            end
            n_checks++;
            if (stall_cycles !== CNT_W'((c <= 1) ? 0 : ((c >= 4) ? 3 : c - 1))) begin
                n_fail++;
                $display("FAIL loaduse_count c=%0d got %0d want %0d", c, stall_cycles,
                         (c <= 1) ? 0 : ((c >= 4) ? 3 : c - 1));
            end
            if (c == 7) begin
                n_checks++;
                if ({RegWriteW, MemToRegW} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL loaduse_add_w got %b want 10", {RegWriteW, MemToRegW});
                end
            end
            n_checks++;
            if ({MemToRegW, RegWriteW} !== {cw.m2r, cw.rw}) begin
                n_fail++;
                $display("FAIL loaduse_ctl_w c=%0d got %b want %b", c, {MemToRegW, RegWriteW}, {cw.m2r, cw.rw});
            end
            advance();
        end
    endtask

    task automatic test_branch();
        do_reset(1);
        zero_drv = 1'b1;
        prog.push_back(mk(6'b000100, 6'd4, 5'd1, 5'd1, 5'd0));
        prog.push_back(mk(6'b101011, 6'd0, 5'd0, 5'd1, 5'd0));
        prog.push_back(mk(6'b101011, 6'd4, 5'd0, 5'd1, 5'd0));
        prog.push_back(mk(6'b001000, 6'd1, 5'd0, 5'd6, 5'd6));
        cur_d = prog.pop_front();
        for (int c = 0; c < 10; c++) begin
            drive_eval();
            n_checks++;
            if ({PCSrcM, FlushD, StallD} !== {c == 2, c == 2, 1'b0}) begin
                n_fail++;
                $display("FAIL branch_pcsrc c=%0d got %b want %b", c, {PCSrcM, FlushD, StallD}, {c == 2, c == 2, 1'b0});
            end
            n_checks++;
            if (MemWriteM !== 1'b0) begin
                n_fail++;
                $display("FAIL branch_memwrite c=%0d got %b want 0", c, MemWriteM);
            end
            n_checks++;
            if (retired !== m_ret) begin
                n_fail++;
                $display("FAIL branch_retired_model c=%0d got %0d want %0d", c, retired, m_ret);
            end
            if (c == 8) begin
                n_checks++;
                if (retired !== CNT_W'(2)) begin
                    n_fail++;
                    $display("FAIL branch_retired got %0d want 2", retired);
                end
            end
            advance();
        end
        zero_drv = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset(1);
        prog.push_back(mk(6'b111111, 6'd0, 5'd0, 5'd0, 5'd9));
        cur_d = prog.pop_front();
        for (int c = 0; c < 5; c++) begin
            drive_eval();
            n_checks++;
            if (illegal_op !== (c == 1)) begin
                n_fail++;
                $display("FAIL illegal_pulse c=%0d got %b want %b", c, illegal_op, c == 1);
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if ({MemWriteM, RegWriteW} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL illegal_no_write c=%0d got %b want 00", c, {MemWriteM, RegWriteW});
                end
            end
            advance();
        end
    endtask

    task automatic test_hazard_flush();
        do_reset(1);
        zero_drv = 1'b1;
        prog.push_back(mk(6'b000100, 6'd0, 5'd1, 5'd1, 5'd0));
        prog.push_back(mk(6'b001000, 6'd1, 5'd0, 5'd7, 5'd7));
        prog.push_back(mk(6'd0, 6'b100000, 5'd7, 5'd7, 5'd8));
        cur_d = prog.pop_front();
        for (int c = 0; c < 6; c++) begin
            drive_eval();
            if (c == 2 || c == 3) begin
                n_checks++;
                if ({StallF, StallD, FlushD} !== {1'b0, 1'b0, c == 2}) begin
                    n_fail++;
                    $display("FAIL hzflush c=%0d got %b want %b", c, {StallF, StallD, FlushD}, {1'b0, 1'b0, c == 2});
                end
            end
            if (c >= 3) begin
                n_checks++;
                if (RegWriteW !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hzflush_squash c=%0d got %b want 0", c, RegWriteW);
                end
            end
            advance();
        end
        zero_drv = 1'b0;

        // Reset arriving while a load-use stall is in progress.
        do_reset(1);
        prog.push_back(mk(6'b100011, 6'd0, 5'd0, 5'd2, 5'd2));
        prog.push_back(mk(6'd0, 6'b100000, 5'd2, 5'd2, 5'd4));
        cur_d = prog.pop_front();
        drive_eval();
        advance();
        drive_eval();
        n_checks++;
        if (StallD !== 1'b1) begin
            n_fail++;
            $display("FAIL rststall_setup got %b want 1", StallD);
        end
        reset = 1'b0;
        advance();
        reset = 1'b1;
        drive_eval();
        n_checks++;
        if ({StallD, StallF, stall_cycles, retired} !== '0) begin
            n_fail++;
            $display("FAIL rststall_cleared got stall=%b cnt=%0d ret=%0d want 0", StallD, stall_cycles, retired);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            if (prog.size() == 0) prog.push_back(rand_instr());
            zero_drv = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            drive_eval();
            n_checks++;
            if ({RegDstE, ALUSrcBE, ALUControlE} !== {ce.rd, ce.asrc, ce.alu}) begin
                n_fail++;
                $display("FAIL rand_ctl_e c=%0d got %b want %b", c, {RegDstE, ALUSrcBE, ALUControlE}, {ce.rd, ce.asrc, ce.alu});
            end
            n_checks++;
            if ({MemWriteM, PCSrcM} !== {cm.mw, x_pcsrc}) begin
                n_fail++;
                $display("FAIL rand_ctl_m c=%0d got %b want %b", c, {MemWriteM, PCSrcM}, {cm.mw, x_pcsrc});
            end
            n_checks++;
            if ({MemToRegW, RegWriteW} !== {cw.m2r, cw.rw}) begin
                n_fail++;
                $display("FAIL rand_ctl_w c=%0d got %b want %b", c, {MemToRegW, RegWriteW}, {cw.m2r, cw.rw});
            end
            n_checks++;
            if ({StallF, StallD, FlushD} !== {x_stall, x_stall, x_pcsrc}) begin
                n_fail++;
                $display("FAIL rand_hazard c=%0d got %b want %b", c, {StallF, StallD, FlushD}, {x_stall, x_stall, x_pcsrc});
            end
            n_checks++;
            if (illegal_op !== m_ill) begin
                n_fail++;
                $display("FAIL rand_illegal c=%0d got %b want %b", c, illegal_op, m_ill);
            end
            n_checks++;
            if (retired !== m_ret) begin
                n_fail++;
                $display("FAIL rand_retired c=%0d got %0d want %0d", c, retired, m_ret);
            end
            n_checks++;
            if (stall_cycles !== m_stall) begin
                n_fail++;
                $display("FAIL rand_stalls c=%0d got %0d want %0d", c, stall_cycles, m_stall);
            end
            advance();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        zero_drv = 1'b0;
        model_reset();
        Opcode = '0; Funct = '0; RsD = '0; RtD = '0; ZeroM = 1'b0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        @(negedge clk);
        test_reset();
        test_independent();
        test_load_use();
        test_branch();
        test_illegal();
        test_hazard_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Control and hazard unit for the 5-stage pipelined MIPS-subset datapath (F/D/E/M/W).
- Decodes Opcode/Funct in D and carries control bits through E, M, W pipeline registers, in step with the datapath's stage registers.
- Detects RAW hazards and stalls F/D; resolves taken branches in M by squashing younger instructions.
- Keeps retired-instruction and stall-cycle counters for bring-up.

Parameters:
REG_AW, 5, register-specifier width
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
Opcode  in  6  InstrD[31:26]
Funct  in  6  InstrD[5:0]
RsD  in  REG_AW  InstrD[25:21]
RtD  in  REG_AW  InstrD[20:16]
ZeroM  in  1  registered ALU zero of instruction in M
WriteRegE  in  REG_AW  destination register in E, after RegDst mux
WriteRegM  in  REG_AW  destination register in M
WriteRegW  in  REG_AW  destination register in W
RegDstE  out  1  select Rd (1) / Rt (0)
ALUSrcBE  out  1  select SignImm (1) / register B (0)
ALUControlE  out  3  ALU op
MemWriteM  out  1  data-memory write enable
PCSrcM  out  1  BranchM & ZeroM, selects PCBranchM
MemToRegW  out  1  select ReadDataW (1) / ALUOutW (0)
RegWriteW  out  1  register-file write enable
StallF  out  1  hold PC register
StallD  out  1  hold D-stage registers
FlushD  out  1  clear InstrD to nop
illegal_op  out  1  1-cycle pulse, unknown opcode/funct decoded
retired  out  CNT_W  instructions that completed W with valid bit
stall_cycles  out  CNT_W  cycles with StallD=1

Behaviour:
- Decode (combinational in D), ALUControl encoding add 010, sub 110, and 000, or 001, slt 111:
  - R-type 000000: RegWrite=1, RegDst=1, ALUSrcB=0; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - lw 100011: RegWrite=1, MemToReg=1, ALUSrcB=1, add.
  - sw 101011: MemWrite=1, ALUSrcB=1, add.
  - beq 000100: Branch=1, sub.
  - addi 001000: RegWrite=1, ALUSrcB=1, add.
  - Instruction word 0 (sll $0 nop) decodes as R-type with RegWrite to $0; treated as valid, no effect.
  - Any other opcode/funct: all control bits 0, valid=1, illegal_op asserted on the following cycle for one cycle.
- Pipeline registers:
  - D->E: {valid, RegWrite, MemToReg, MemWrite, Branch, RegDst, ALUSrcB, ALUControl}.
  - E->M: {valid, RegWrite, MemToReg, MemWrite, Branch}.
  - M->W: {valid, RegWrite, MemToReg}.
- Hazard (no forwarding in datapath):
  - hazard = (RsD or RtD) matches a nonzero WriteRegX whose RegWriteX=1, for X in {E, M, W}.
  - RtD is compared for every opcode.
  - The W-stage match is required because register-file write and read in the same cycle is not bypassed.
- On hazard: StallF=StallD=1. The D->E register loads a bubble (all control 0, valid 0). E/M/W advance normally.
- Branch: PCSrcM = BranchM & ZeroM, combinational from the M register.
- When PCSrcM=1:
  - FlushD=1.
  - Next cycle the E and M stage control registers load bubbles, squashing the instructions in D and E.
  - StallF/StallD are forced 0 (flush has priority over stall).
  - The branch itself advances to W normally.
- Latency: decoded control reaches E outputs 1 cycle after D, M after 2, W after 3.
- Counters:
  - retired increments when validW=1.
  - stall_cycles increments when StallD=1.
  - Both wrap modulo 2^CNT_W, no saturation.
- Reset (reset=0 at a clk edge):
  - All pipeline control registers, counters and illegal_op go to 0.
  - All outputs are 0 the cycle after reset: no writes, PCSrcM=0, no stall.
  - Reset mid-stall or mid-flush discards the pending state.

Test Plan:
- Reset held low 2 cycles, then release with InstrD = nop: all outputs 0, retired=0; first retire 3 cycles after release, retired=1.
- add $3,$1,$2 then an independent addi $5,$4,7: no stall. E-stage RegDstE=1 ALUControlE=010, then ALUSrcBE=1. RegWriteW=1 on cycles 3 and 4.
- lw $2,0($0) followed by add $4,$2,$2: StallD=1 for exactly 3 cycles (matches on E, M, W). stall_cycles=3. add reaches W with RegWriteW=1, MemToRegW=0.
- beq $1,$1,+4 with 2 following sw instructions: PCSrcM=1 exactly one cycle, FlushD=1 that cycle. MemWriteM never 1 for the squashed sw instructions. retired counts only beq plus the target.
- Opcode 111111 in D: illegal_op=1 one cycle later for one cycle. RegWriteW and MemWriteM remain 0 for that instruction.
- Hazard and PCSrcM=1 in the same cycle: StallF=0, FlushD=1. Also assert reset=0 during a stall: StallD=0 the next cycle.
